// File: rtl/crc_pkg.sv
// Shared CRC arithmetic used by both the serial generator and the serial checker
// so the two ends of the link always agree on the polynomial step.
package crc_pkg;

  localparam int             DEF_DATA_W = 10;
  localparam int             DEF_CRC_W  = 3;
  localparam logic [2:0]     DEF_POLY   = 3'b011;  // x^3 + x + 1, x^3 implicit
  localparam int             CRC_MAX    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // One LFSR step for a width-bit register held in the low bits of a CRC_MAX vector.
  function automatic logic [CRC_MAX-1:0] crc_step(
    input logic [CRC_MAX-1:0] lfsr,
    input logic               in_bit,
    input logic [CRC_MAX-1:0] poly,
    input int                 width
  );
    logic [CRC_MAX-1:0] mask;
    logic [CRC_MAX-1:0] shifted;
    logic               fb;
    mask    = (width >= CRC_MAX) ? '1 : ((CRC_MAX'(1) << width) - CRC_MAX'(1));
    fb      = in_bit ^ (|(lfsr & (CRC_MAX'(1) << (width - 1))));
    shifted = (lfsr << 1) & mask;
    return shifted ^ (fb ? (poly & mask) : '0);
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// Serial CRC register: steps on enable, can restart from the zero state on the
// current bit, and clears synchronously.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int               CRC_W = DEF_CRC_W,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step_en,
  input  logic             restart,
  input  logic             in_bit,
  output logic [CRC_W-1:0] lfsr,
  output logic [CRC_W-1:0] lfsr_next
);

  logic [CRC_MAX-1:0] step_full;

  always_comb begin
    step_full = crc_step(restart ? '0 : CRC_MAX'(lfsr), in_bit, CRC_MAX'(POLY), CRC_W);
    lfsr_next = step_full[CRC_W-1:0];
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values, matching the hardware regardless of block order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lfsr <= '0;
    end else if (step_en) begin
      lfsr <= lfsr_next;
    end
  end

endmodule

// File: rtl/crc_serial_checker.sv
// Serial CRC receive stage: checks a DATA_W+CRC_W codeword arriving MSB first and
// returns the message plus a pass flag on a valid/ready port; counts bad frames.
module crc_serial_checker
  import crc_pkg::*;
#(
  parameter int               DATA_W = DEF_DATA_W,
  parameter int               CRC_W  = DEF_CRC_W,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(DEF_POLY),
  parameter int               ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_bit,
  input  logic              in_sof,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              crc_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ERR_W-1:0]  err_count
);

  localparam int FRAME_LEN = DATA_W + CRC_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   msg;
  logic [CRC_W-1:0]    lfsr;
  logic [CRC_W-1:0]    lfsr_next;
  logic                accept;
  logic                taken;
  logic                lfsr_step;
  logic                err_full;

  assign in_ready  = !reset && (state != ST_DONE);
  assign accept    = in_valid && in_ready;
  assign taken     = out_valid && out_ready;
  assign err_full  = (err_count == {ERR_W{1'b1}});
  // Junk bits in IDLE never touch the LFSR; a sof bit always restarts it from zero.
  assign lfsr_step = accept && (in_sof || state == ST_SHIFT);

  crc_lfsr #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .clear     (taken),
    .step_en   (lfsr_step),
    .restart   (in_sof),
    .in_bit    (in_bit),
    .lfsr      (lfsr),
    .lfsr_next (lfsr_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      msg       <= '0;
      data_out  <= '0;
      crc_ok    <= 1'b0;
      out_valid <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && in_sof) begin
            cnt   <= CNT_W'(1);
            msg   <= DATA_W'(in_bit);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (accept && in_sof) begin
            cnt <= CNT_W'(1);
            msg <= DATA_W'(in_bit);
            if (!err_full) err_count <= err_count + ERR_W'(1);
          end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt < CNT_W'(DATA_W)) msg <= {msg[DATA_W-2:0], in_bit};
            // The last bit is always a CRC bit, so msg is already complete here.
            if (cnt == CNT_W'(FRAME_LEN - 1)) begin
              data_out  <= msg;
              crc_ok    <= (lfsr_next == '0);
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            state     <= ST_IDLE;
            if (!crc_ok && !err_full) err_count <= err_count + ERR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc_serial_checker.md
Name: crc_serial_checker

Overview:
Downstream receive stage for the serial CRC generator. Accepts a codeword (DATA_W message bits followed by CRC_W check bits) one bit per cycle, MSB first. Runs the same LFSR over the whole codeword and presents the recovered message with a pass/fail flag on a valid/ready output port. Keeps a saturating count of failed and aborted frames.

Parameters:
DATA_W, 10, message bits per frame
CRC_W, 3, CRC width (generator degree)
POLY, 3'b011, generator low-order terms, x^CRC_W implicit (default x^3+x+1)
ERR_W, 8, error counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_bit  in  1  serial codeword bit, MSB first
in_sof  in  1  qualifies in_bit as first bit of a frame
in_valid  in  1  in_bit/in_sof valid this cycle
in_ready  out  1  checker accepts a bit this cycle
data_out  out  DATA_W  recovered message, held while out_valid
crc_ok  out  1  1 = remainder zero, qualified by out_valid
out_valid  out  1  frame result available
out_ready  in  1  consumer takes result
err_count  out  ERR_W  saturating count of failed and aborted frames

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high, named reset. While reset is high, at each rising edge: state=IDLE, lfsr=0, bit counter=0, data_out=0, crc_ok=0, out_valid=0, err_count=0. in_ready is 0 during reset.
- Handshake: a bit is accepted when in_valid && in_ready. A result is taken when out_valid && out_ready.
- in_ready: 1 in IDLE and SHIFT; 0 in DONE.
- LFSR step on each accepted bit:
  - fb = lfsr[CRC_W-1] ^ in_bit
  - lfsr_next = {lfsr[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
- Message capture: the first DATA_W accepted bits shift into a message register, MSB first. The CRC bits only enter the LFSR.
- State IDLE:
  - An accepted bit with in_sof=1: lfsr is seeded from the zero state with that bit, cnt=1, go to SHIFT.
  - An accepted bit with in_sof=0 is discarded. No counter change.
- State SHIFT:
  - Each accepted bit steps the LFSR and increments cnt.
  - When the bit making cnt == DATA_W+CRC_W is accepted, go to DONE next cycle with data_out=message and crc_ok=(lfsr_next==0). out_valid rises the cycle after that last bit (latency 1).
  - in_valid low pauses the frame. Gaps of any length are allowed.
- Abort in SHIFT: an accepted bit with in_sof=1 abandons the partial frame. err_count increments (saturating). The LFSR reseeds from zero with this bit, cnt=1, and the FSM stays in SHIFT.
- State DONE:
  - out_valid=1. data_out and crc_ok are stable until the result is taken.
  - On handshake: go to IDLE. If crc_ok=0, err_count increments (saturating) on the same edge.
  - Back-to-back frames cost one idle cycle (in_ready is low in DONE).
- err_count: saturates at 2^ERR_W-1, never wraps.
- Reset mid-frame or mid-DONE: the frame is dropped, all state cleared, no error counted.
- Counter width: clog2(DATA_W+CRC_W+1).

Decomposition:
- Shared package crc_pkg: CRC_W, DATA_W, POLY defaults, and a function crc_step(lfsr, bit) returning the next LFSR state. The generator uses the same function, so both ends use identical polynomial arithmetic.
- Sub-module crc_lfsr (step-enable, sync clear) is natural. The top holds the FSM, bit counter, message register and error counter.

Test Plan:
- Good frame: reset 2 cycles, then codeword 1100000011_100 sent continuously, sof on first bit -> out_valid 1 cycle after bit 13, data_out=10'b1100000011, crc_ok=1, err_count=0.
- Corrupt frame: same codeword with CRC field 101 -> crc_ok=0. After handshake, err_count=1.
- Gaps and backpressure: in_valid toggled randomly mid-frame, out_ready held low 5 cycles -> same result as the good frame. in_ready=0 throughout DONE. out_valid and data_out stable until handshake.
- Abort: sof reasserted at bit 6, then a full good frame follows -> err_count=1, one result with crc_ok=1 and data_out=10'b1100000011.
- Idle junk and reset: bits without sof in IDLE are ignored (no result). A reset pulse at bit 8 of a frame -> no out_valid, err_count unchanged (0), next good frame passes.
- Saturation (ERR_W=2): 5 corrupt frames -> err_count sequence 1,2,3,3,3.
